seg7_scan_mux: RTL and testbench

- Consumer side of the display-enable divider in the 7-segment peripheral.
- Takes the divider's toggling enable level and steps a time-multiplexed scan across NUM_DIGITS common-anode digits.
- Drives anodes, segments and decimal point, with dead-time blanking between digits, hex decoding, leading-zero suppression and frame-synchronous value update.
- Sits between the CPU-facing display register and the board pins.

---
 rtl/seg7_scan_mux.sv | 130 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan driver for NUM_DIGITS common-anode 7-segment digits.
// Blanks between digits, decodes hex, and loads new values only at frame boundaries.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    lz_en_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int              IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0]   LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]      BLAST = 8'(BLANK_CYCLES - 1);
  localparam logic            POL   = (ACTIVE_LOW != 0);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [IW-1:0]           idx;
  logic                    en_q;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic                    pend_lz, act_lz;

  logic                    step, boundary, upper_nz;
  logic [IW-1:0]           nidx;
  logic [4*NUM_DIGITS-1:0] src_val, nval;
  logic [NUM_DIGITS-1:0]   src_dp, ndp, anode_n;
  logic                    src_lz, nlz;
  logic [3:0]              nib;
  logic [6:0]              seg_n;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Decode is computed for the digit about to be shown, so the output
  // registers update on the same edge as the BLANK->SHOW transition.
  always_comb begin
    step     = (en_i != en_q);
    nidx     = (idx == LAST) ? '0 : idx + IW'(1);
    boundary = (state == BLANK) && (cnt == BLAST) && (nidx == '0);
    src_val  = load_i ? value_i : pend_val;
    src_dp   = load_i ? dp_i    : pend_dp;
    src_lz   = load_i ? lz_en_i : pend_lz;
    nval     = boundary ? src_val : act_val;
    ndp      = boundary ? src_dp  : act_dp;
    nlz      = boundary ? src_lz  : act_lz;
    nib      = nval[int'(nidx)*4 +: 4];
    upper_nz = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (IW'(j) >= nidx && nval[j*4 +: 4] != 4'h0) upper_nz = 1'b1;
    end
    seg_n   = (nlz && nidx != '0 && !upper_nz) ? 7'h00 : hex7(nib);
    anode_n = NUM_DIGITS'(1) << nidx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BLANK;
      cnt      <= '0;
      idx      <= LAST;
      en_q     <= en_i;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_lz  <= 1'b0;
      act_val  <= '0;
      act_dp   <= '0;
      act_lz   <= 1'b0;
      anode_o  <= {NUM_DIGITS{POL}};
      seg_o    <= {7{POL}};
      dp_o     <= POL;
      frame_o  <= 1'b0;
    end else begin
      en_q    <= en_i;
      frame_o <= 1'b0;
      if (load_i) begin
        pend_val <= value_i;
        pend_dp  <= dp_i;
        pend_lz  <= lz_en_i;
      end
      case (state)
        SHOW: begin
          if (step) begin
            state   <= BLANK;
            cnt     <= '0;
            anode_o <= {NUM_DIGITS{POL}};
            seg_o   <= {7{POL}};
            dp_o    <= POL;
          end
        end
        BLANK: begin
          if (cnt == BLAST) begin
            state   <= SHOW;
            idx     <= nidx;
            anode_o <= anode_n ^ {NUM_DIGITS{POL}};
            seg_o   <= seg_n ^ {7{POL}};
            dp_o    <= ndp[nidx] ^ POL;
            if (boundary) begin
              act_val <= src_val;
              act_dp  <= src_dp;
              act_lz  <= src_lz;
              frame_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with default parameters (4 digits, 2 blank cycles, active-low).
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst, en_i, load_i, lz_en_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic        dp_o, frame_o;

  int errors = 0;
  int checks = 0;

  logic [3:0] an;
  logic [6:0] sg;
  logic       d, fr;
  logic [7:0] offc;

  seg7_scan_mux #(.NUM_DIGITS(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .value_i(value_i), .dp_i(dp_i),
    .load_i(load_i), .lz_en_i(lz_en_i), .anode_o(anode_o), .seg_o(seg_o),
    .dp_o(dp_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    value_i = v; dp_i = dp; lz_en_i = lz; load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  // Toggles the enable, then waits (bounded) for the next digit, counting all-off cycles.
  task automatic show_next(output logic [3:0] a, output logic [6:0] s, output logic dd,
                           output logic f, output logic [7:0] oc);
    en_i = ~en_i;
    oc = 8'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (anode_o !== 4'hF) break;
      oc++;
    end
    a = anode_o; s = seg_o; dd = dp_o; f = frame_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({anode_o, seg_o, dp_o, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_outputs: got %h %h %b %b, expected F 7f 1 0", anode_o, seg_o, dp_o, frame_o);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({anode_o, frame_o} !== {4'hF, 1'b0}) begin
      errors++; $display("FAIL reset_blank1: got anode %h frame %b, expected F 0", anode_o, frame_o);
    end
    tick();
    checks++;
    if ({anode_o, seg_o, dp_o, frame_o} !== {4'hE, 7'h40, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_first_digit: got %h %h %b %b, expected E 40 1 1", anode_o, seg_o, dp_o, frame_o);
    end
    tick();
    checks++;
    if ({anode_o, frame_o} !== {4'hE, 1'b0}) begin
      errors++; $display("FAIL reset_frame_single: got anode %h frame %b, expected E 0", anode_o, frame_o);
    end
  endtask

  task automatic test_hex();
    do_load(16'h12AF, 4'b0100, 1'b0);
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hD, 7'h40, 1'b1, 1'b0}) begin
      errors++; $display("FAIL hex_old_frame_d1: got %h %h %b %b, expected D 40 1 0", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    show_next(an, sg, d, fr, offc);
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr, offc} !== {4'hE, 7'h0E, 1'b1, 1'b1, 8'd2}) begin
      errors++; $display("FAIL hex_d0: got %h %h %b %b off=%0d, expected E 0e 1 1 off=2", an, sg, d, fr, offc);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr, offc} !== {4'hD, 7'h08, 1'b1, 1'b0, 8'd2}) begin
      errors++; $display("FAIL hex_d1: got %h %h %b %b off=%0d, expected D 08 1 0 off=2", an, sg, d, fr, offc);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr, offc} !== {4'hB, 7'h24, 1'b0, 1'b0, 8'd2}) begin
      errors++; $display("FAIL hex_d2: got %h %h %b %b off=%0d, expected B 24 0 0 off=2", an, sg, d, fr, offc);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr, offc} !== {4'h7, 7'h79, 1'b1, 1'b0, 8'd2}) begin
      errors++; $display("FAIL hex_d3: got %h %h %b %b off=%0d, expected 7 79 1 0 off=2", an, sg, d, fr, offc);
    end
  endtask

  task automatic test_lz();
    do_load(16'h0050, 4'b0000, 1'b1);
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hE, 7'h40, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lz_d0: got %h %h %b %b, expected E 40 1 1", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hD, 7'h12, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lz_d1: got %h %h %b %b, expected D 12 1 0", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hB, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lz_d2: got %h %h %b %b, expected B 7f 1 0", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'h7, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lz_d3: got %h %h %b %b, expected 7 7f 1 0", an, sg, d, fr);
    end
  endtask

  task automatic test_midframe_load();
    show_next(an, sg, d, fr, offc);
    show_next(an, sg, d, fr, offc);
    do_load(16'h1111, 4'b0000, 1'b0);
    tick();
    do_load(16'h2222, 4'b0000, 1'b0);
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hB, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_d2_unchanged: got %h %h %b %b, expected B 7f 1 0", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'h7, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_d3_unchanged: got %h %h %b %b, expected 7 7f 1 0", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hE, 7'h24, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mid_next_d0: got %h %h %b %b, expected E 24 1 1", an, sg, d, fr);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hD, 7'h24, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_next_d1: got %h %h %b %b, expected D 24 1 0", an, sg, d, fr);
    end
  endtask

  task automatic test_boundary_load();
    show_next(an, sg, d, fr, offc);
    show_next(an, sg, d, fr, offc);
    en_i = ~en_i;
    tick();
    tick();
    value_i = 16'h4567; dp_i = 4'b0001; lz_en_i = 1'b0; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    checks++;
    if ({anode_o, seg_o, dp_o, frame_o} !== {4'hE, 7'h78, 1'b0, 1'b1}) begin
      errors++; $display("FAIL bypass_d0: got %h %h %b %b, expected E 78 0 1", anode_o, seg_o, dp_o, frame_o);
    end
    show_next(an, sg, d, fr, offc);
    checks++;
    if ({an, sg, d, fr} !== {4'hD, 7'h02, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bypass_d1: got %h %h %b %b, expected D 02 1 0", an, sg, d, fr);
    end
  endtask

  task automatic test_back_to_back();
    int bad_hot = 0;
    int moved = 0;
    logic [7:0] oc = 8'd0;
    en_i = ~en_i;
    tick();
    if (anode_o === 4'hF) oc++;
    en_i = ~en_i;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (anode_o !== 4'hF) break;
      oc++;
    end
    checks++;
    if ({anode_o, seg_o, dp_o, oc} !== {4'hB, 7'h12, 1'b1, 8'd2}) begin
      errors++; $display("FAIL double_step_d2: got %h %h %b off=%0d, expected B 12 1 off=2", anode_o, seg_o, dp_o, oc);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (anode_o !== 4'hB) moved++;
    end
    checks++;
    if (moved !== 0) begin
      errors++; $display("FAIL double_step_hold: got %0d moved cycles, expected 0", moved);
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) en_i = ~en_i;
      tick();
      if (anode_o !== 4'hF && !$onehot(~anode_o)) bad_hot++;
    end
    checks++;
    if (bad_hot !== 0) begin
      errors++; $display("FAIL anode_onehot: got %0d bad cycles, expected 0", bad_hot);
    end
  endtask

  task automatic test_reset_mid();
    show_next(an, sg, d, fr, offc);
    rst = 1'b1;
    tick();
    checks++;
    if ({anode_o, seg_o, dp_o, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midreset_off: got %h %h %b %b, expected F 7f 1 0", anode_o, seg_o, dp_o, frame_o);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({anode_o, seg_o, dp_o, frame_o} !== {4'hE, 7'h40, 1'b1, 1'b1}) begin
      errors++; $display("FAIL midreset_restart: got %h %h %b %b, expected E 40 1 1", anode_o, seg_o, dp_o, frame_o);
    end
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; load_i = 1'b0; lz_en_i = 1'b0;
    value_i = '0; dp_i = '0;
    tick();
    test_reset();
    test_hex();
    test_lz();
    test_midframe_load();
    test_boundary_load();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
